// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word-aligned reads under a credit limit,
// buffers in-order responses in a small queue, and drains stale reads after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus_4,
  output logic [31:0] if_instruction
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam int unsigned PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FQ_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    S_FETCH,
    S_DISCARD
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [31:0]   pc_mem_q    [FQ_DEPTH];
  logic [31:0]   instr_mem_q [FQ_DEPTH];

  logic [CW:0]   credit;
  logic          grant;
  logic          accept;
  logic          pop;
  logic [31:0]   resp_pc;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    credit    = {1'b0, out_q} + {1'b0, cnt_q};
    imem_req  = ~rst & ~redirect & (state_q == S_FETCH) & (credit < DEPTH_W);
    imem_addr = fetch_pc_q;
    grant     = imem_req & imem_gnt;
    accept    = imem_rvalid & (state_q == S_FETCH) & ~redirect;
    pop       = (cnt_q != '0) & ~stall & ~redirect;
    // In FETCH all live requests are consecutive words ending just below fetch_pc,
    // so the oldest one (the one answering now) sits out_q words back.
    resp_pc   = fetch_pc_q - (32'(out_q) << 2);
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    out_d      = out_q;
    drop_d     = drop_q;
    cnt_d      = cnt_q + CW'(accept) - CW'(pop);
    head_d     = pop ? ptr_inc(head_q) : head_q;
    tail_d     = accept ? ptr_inc(tail_q) : tail_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc & ~32'h3;
      cnt_d      = '0;
      head_d     = '0;
      tail_d     = '0;
      out_d      = '0;
      if (state_q == S_FETCH) begin
        drop_d = out_q - CW'(imem_rvalid);
      end else begin
        drop_d = drop_q - CW'(imem_rvalid & (drop_q != '0));
      end
      state_d = (drop_d != '0) ? S_DISCARD : S_FETCH;
    end else if (state_q == S_DISCARD) begin
      if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (drop_d == '0) begin
        state_d = S_FETCH;
      end
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      out_d = out_q + CW'(grant) - CW'(accept);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_FETCH;
      fetch_pc_q <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_mem_q[tail_q]    <= resp_pc;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

  always_comb begin
    if_valid       = (cnt_q != '0);
    if_pc          = if_valid ? pc_mem_q[head_q] : '0;
    if_pc_plus_4   = if_valid ? pc_mem_q[head_q] + 32'd4 : '0;
    if_instruction = if_valid ? instr_mem_q[head_q] : NOP;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model with an in-order memory responder,
// compared every cycle, plus directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int unsigned FQ_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic [31:0] if_instruction;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus_4(if_pc_plus_4),
    .if_instruction(if_instruction)
  );

  typedef struct { logic [31:0] addr; bit stale; int unsigned ready; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;

  req_t pend[$];
  ent_t mq[$];
  req_t r;
  logic [31:0] m_pc = RESET_PC;
  int unsigned cyc = 0;
  bit model_ok = 0;
  int checks = 0;
  int errors = 0;

  bit c_rst = 1, c_stall = 0, c_redir = 0, c_gnt = 1, c_rv_en = 1;
  logic [31:0] c_rpc = '0;
  int unsigned c_lat = 1;
  bit l_rst = 1, l_stall = 0, l_redir = 0, l_gnt = 0, rv = 0, e_req = 0;
  logic [31:0] l_rpc = '0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int stale_cnt();
    int n = 0;
    foreach (pend[i]) if (pend[i].stale) n++;
    return n;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (pend[i]) if (!pend[i].stale) n++;
    return n;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, then compare against the model.
  initial forever begin
    @(negedge clk);
    l_rst = c_rst; l_stall = c_stall; l_redir = c_redir; l_rpc = c_rpc; l_gnt = c_gnt;
    rst = c_rst; stall = c_stall; redirect = c_redir; redirect_pc = c_rpc; imem_gnt = c_gnt;
    rv = c_rv_en && (pend.size() > 0) && (pend[0].ready <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_data(pend[0].addr) : 32'hDEAD_BEEF;
    e_req = !c_rst && !c_redir && (stale_cnt() == 0) && (live_cnt() + mq.size() < FQ_DEPTH);
    #1;
    if (model_ok) begin
      check32("m_imem_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) check32("m_imem_addr", imem_addr, m_pc);
      check32("m_if_valid", {31'b0, if_valid}, {31'b0, mq.size() > 0});
      check32("m_if_pc", if_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
      check32("m_if_pc_plus_4", if_pc_plus_4, (mq.size() > 0) ? mq[0].pc + 32'd4 : 32'h0);
      check32("m_if_instruction", if_instruction, (mq.size() > 0) ? mq[0].instr : 32'h13);
    end
  end

  // Model and memory advance on the rising edge from the values latched above.
  initial forever begin
    @(posedge clk);
    if (l_rst) begin
      pend.delete();
      mq.delete();
      m_pc = RESET_PC;
      model_ok = 1;
    end else begin
      if (mq.size() > 0 && !l_stall && !l_redir) void'(mq.pop_front());
      if (rv) begin
        r = pend.pop_front();
        if (!r.stale && !l_redir) mq.push_back('{pc: r.addr, instr: mem_data(r.addr)});
      end
      if (l_redir) begin
        mq.delete();
        foreach (pend[i]) pend[i].stale = 1;
        m_pc = l_rpc & ~32'h3;
      end
      if (e_req && l_gnt) begin
        pend.push_back('{addr: m_pc, stale: 0, ready: cyc + c_lat});
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  end

  task automatic at_cycle();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset(input int unsigned lat);
    @(posedge clk);
    c_rst = 1; c_stall = 0; c_redir = 0; c_gnt = 1; c_rv_en = 1; c_lat = lat;
    @(negedge clk);
    at_cycle();
    check32("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check32("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check32("rst_if_pc", if_pc, 32'h0);
    check32("rst_if_pc_plus_4", if_pc_plus_4, 32'h0);
    check32("rst_if_instruction", if_instruction, 32'h0000_0013);
    @(posedge clk);
    c_rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    // Streaming with 1-cycle latency: depth 2 credit gives a fetch every other cycle.
    do_reset(1);
    at_cycle();  // R0
    check32("stream_first_req", {31'b0, imem_req}, 32'd1);
    check32("stream_first_addr", imem_addr, RESET_PC);
    at_cycle();  // R1
    check32("stream_r1_addr", imem_addr, 32'h4);
    at_cycle();  // R2
    check32("stream_r2_pc", if_pc, 32'h0);
    check32("stream_r2_pc4", if_pc_plus_4, 32'h4);
    check32("stream_r2_instr", if_instruction, 32'h5A5A_0F0F);
    check32("stream_r2_req", {31'b0, imem_req}, 32'd0);
    at_cycle();  // R3
    check32("stream_r3_pc", if_pc, 32'h4);
    check32("stream_r3_addr", imem_addr, 32'h8);
    repeat (8) at_cycle();

    // Backpressure: stall held for five cycles.
    do_reset(1);
    c_stall = 1;
    at_cycle(); at_cycle(); at_cycle();  // R0..R2
    at_cycle();  // R3
    check32("bp_full_req", {31'b0, imem_req}, 32'd0);
    check32("bp_hold_pc", if_pc, 32'h0);
    at_cycle();  // R4
    check32("bp_hold_valid", {31'b0, if_valid}, 32'd1);
    c_stall = 0;
    at_cycle();  // R5
    at_cycle();  // R6
    check32("bp_next_pc", if_pc, 32'h4);
    check32("bp_next_addr", imem_addr, 32'h8);
    repeat (6) at_cycle();

    // Redirect with two requests in flight.
    do_reset(3);
    at_cycle(); at_cycle();  // R0, R1
    c_redir = 1; c_rpc = 32'h0000_0100;
    at_cycle();  // R2
    check32("redir_req_low", {31'b0, imem_req}, 32'd0);
    c_redir = 0;
    at_cycle();  // R3
    check32("redir_discard_req", {31'b0, imem_req}, 32'd0);
    at_cycle();  // R4
    at_cycle();  // R5
    check32("redir_new_req", {31'b0, imem_req}, 32'd1);
    check32("redir_new_addr", imem_addr, 32'h100);
    for (int i = 0; i < 12; i++) begin
      if (if_valid === 1'b1) break;
      at_cycle();
    end
    check32("redir_if_valid", {31'b0, if_valid}, 32'd1);
    check32("redir_if_pc", if_pc, 32'h100);
    repeat (4) at_cycle();

    // Redirect coinciding with a response; unaligned target.
    do_reset(2);
    at_cycle(); at_cycle();  // R0, R1
    c_redir = 1; c_rpc = 32'h0000_0103;
    at_cycle();  // R2
    c_redir = 0;
    at_cycle();  // R3
    check32("simul_if_valid", {31'b0, if_valid}, 32'd0);
    check32("simul_req", {31'b0, imem_req}, 32'd0);
    at_cycle();  // R4
    check32("simul_new_req", {31'b0, imem_req}, 32'd1);
    check32("simul_new_addr", imem_addr, 32'h100);
    repeat (6) at_cycle();

    // Address wrap at the top of the 32-bit space.
    do_reset(1);
    c_redir = 1; c_rpc = 32'hFFFF_FFFC;
    at_cycle();  // R0
    c_redir = 0;
    at_cycle();  // R1
    check32("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    at_cycle();  // R2
    check32("wrap_addr1", imem_addr, 32'h0000_0000);
    at_cycle();  // R3
    check32("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
    check32("wrap_if_pc4", if_pc_plus_4, 32'h0000_0000);
    check32("wrap_instr", if_instruction, 32'hA5A5_F0F3);
    repeat (4) at_cycle();

    // Reset with one queued entry and one request in flight.
    do_reset(1);
    c_stall = 1;
    at_cycle(); at_cycle();  // R0, R1
    c_rst = 1;
    at_cycle();  // R2
    at_cycle();  // R3
    check32("mid_rst_valid", {31'b0, if_valid}, 32'd0);
    check32("mid_rst_instr", if_instruction, 32'h0000_0013);
    check32("mid_rst_req", {31'b0, imem_req}, 32'd0);
    c_rst = 0; c_stall = 0;
    at_cycle();  // R4
    check32("mid_rst_req_after", {31'b0, imem_req}, 32'd1);
    check32("mid_rst_addr_after", imem_addr, RESET_PC);
    repeat (4) at_cycle();

    // Mixed traffic: grant gaps, response gaps, stalls and redirects.
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      c_stall = ($urandom_range(0, 3) == 0);
      c_gnt   = ($urandom_range(0, 3) != 0);
      c_rv_en = ($urandom_range(0, 4) != 0);
      c_redir = ($urandom_range(0, 15) == 0);
      c_rpc   = $urandom;
      if ((i % 50) == 0) c_lat = $urandom_range(1, 3);
      at_cycle();
    end
    c_redir = 0; c_stall = 0; c_gnt = 1; c_rv_en = 1;
    repeat (10) at_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
